div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
- Sits directly upstream of the multicycle restoring divider core and downstream of the main control unit.
- On a start pulse it:
  - latches the operands;
  - converts signed operands to magnitudes;
  - holds the core enabled for the fixed iteration count;
  - sign-corrects the remainder and quotient;
  - commits them to the HI/LO registers.
- Also owns HI/LO for mfhi/mflo/mthi/mtlo and reports divide-by-zero to the exception logic.

Parameters:
- DIV_LATENCY, 33, number of consecutive div_en-high cycles before the core outputs are valid.
- WIDTH, 32, operand and result width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a divide.
- is_signed  in  1  sampled with start: 1 = DIV, 0 = DIVU.
- dividend  in  WIDTH  rs operand, sampled with start.
- divisor  in  WIDTH  rt operand, sampled with start.
- div_en  out  1  enable to the divider core; low clears the core.
- div_dividend  out  WIDTH  magnitude of the dividend to the core.
- div_divisor  out  WIDTH  magnitude of the divisor to the core.
- div_rem_in  in  WIDTH  unsigned remainder from the core.
- div_quo_in  in  WIDTH  unsigned quotient from the core.
- div_zero_in  in  1  divide-by-zero flag from the core.
- hi_we  in  1  mthi write strobe.
- lo_we  in  1  mtlo write strobe.
- wdata  in  WIDTH  mthi/mtlo data.
- hi  out  WIDTH  HI register (remainder).
- lo  out  WIDTH  LO register (quotient).
- busy  out  1  high from the cycle after start until done/div_zero.
- done  out  1  one-cycle pulse when HI/LO are updated.
- div_zero  out  1  one-cycle pulse on divide by zero.

Behaviour:
- Reset (async, reset==0): state IDLE; hi, lo, count, operand regs = 0; div_en, busy, done, div_zero = 0.
- States:
  - IDLE
    - start=1 and divisor==0: go to ZERO.
    - start=1 otherwise:
      - latch abs(dividend), abs(divisor) (abs only if is_signed);
      - latch q_neg = is_signed & (dividend[31]^divisor[31]);
      - latch r_neg = is_signed & dividend[31];
      - count=0; go to RUN.
  - RUN
    - div_en=1 and busy=1; div_dividend/div_divisor driven from the latched magnitudes, stable for the whole operation.
    - count increments every cycle.
    - When count==DIV_LATENCY-1, go to COMMIT on the next edge.
    - div_zero_in=1 in any RUN cycle: go to ZERO (defensive; HI/LO untouched).
  - COMMIT
    - div_en=0.
    - hi <= r_neg ? -div_rem_in : div_rem_in.
    - lo <= q_neg ? -div_quo_in : div_quo_in.
    - done=1 for this cycle; go to IDLE.
  - ZERO
    - div_en=0; div_zero=1 for one cycle; HI/LO unchanged; go to IDLE.
- Latency: start at edge N gives done high during cycle N+DIV_LATENCY+1, with HI/LO valid on the same edge done falls.
- busy covers RUN, COMMIT and ZERO.
- Arithmetic:
  - Negation is two's complement, truncated to WIDTH.
  - -2^31 / -1 (signed): magnitude 0x80000000, quotient negated wraps, so lo=0x80000000, hi=0. No trap.
- start while busy: ignored; no queueing.
- hi_we/lo_we:
  - Honoured only in IDLE; ignored while busy.
  - Written on the same edge; visible next cycle.
- start and hi_we in the same IDLE cycle: the write is applied; the divide later overwrites it at COMMIT.
- Reset mid-operation: immediate return to IDLE with div_en=0; no done and no div_zero pulse.

Decomposition:
- Shared package holds:
  - the state encoding enum (IDLE, RUN, COMMIT, ZERO);
  - DIV_LATENCY default;
  - WIDTH constant.
- One natural sub-module, sign_fix: combinational conditional two's-complement negate, instanced for operand abs and for result correction.
- The FSM and HI/LO registers stay in div_sequencer.

Test Plan:
- DIVU 100/7 -> after 34 cycles done=1; hi=2, lo=14; div_en high exactly 33 cycles.
- DIV -7/2 -> hi=0xFFFFFFFF (-1), lo=0xFFFFFFFD (-3); DIV 7/-2 -> hi=1, lo=0xFFFFFFFD.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, done pulses; no div_zero.
- Divisor 0, HI/LO preloaded via mthi=0xAAAA, mtlo=0x5555:
  - div_zero pulses the cycle after start;
  - div_en never rises;
  - HI/LO stay 0xAAAA/0x5555.
- Busy interactions:
  - start again mid-RUN -> ignored; the result is the first operation's.
  - mthi during RUN -> ignored.
  - reset low at count 10 -> hi=lo=0, busy=0 asynchronously; no done pulse.
- Back-to-back: start on the cycle after done -> second result correct; busy low for that one IDLE cycle only.

Source files
------------

// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divide sequencer: default sizes and FSM encoding.
package div_sequencer_pkg;

  localparam int DIV_WIDTH       = 32;
  localparam int DIV_LATENCY_DEF = 33;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_COMMIT = 2'd2,
    ST_ZERO   = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_sequencer_if.sv
// Bundle of control-unit, divider-core and HI/LO access signals around the sequencer.
interface div_sequencer_if
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  // control unit request
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;

  // divider core
  logic             div_en;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic [WIDTH-1:0] div_rem_in;
  logic [WIDTH-1:0] div_quo_in;
  logic             div_zero_in;

  // HI/LO access and status
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    output div_rem_in, div_quo_in, div_zero_in,
    output hi_we, lo_we, wdata,
    input  div_en, div_dividend, div_divisor,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    input  div_rem_in, div_quo_in, div_zero_in,
    input  hi_we, lo_we, wdata,
    output div_en, div_dividend, div_divisor,
    output hi, lo, busy, done, div_zero
  );

endinterface

// File: rtl/div_sequencer_sign_fix.sv
// Conditional two's-complement negate: used for operand magnitudes and result sign correction.
module div_sequencer_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  // Negation wraps, so the most negative value maps to itself.
  assign data_o = neg_i ? ((~data_i) + WIDTH'(1)) : data_i;

endmodule

// File: rtl/div_sequencer.sv
// Divide sequencer: feeds operand magnitudes to the multicycle restoring divider,
// sign-corrects its results into HI/LO, owns mthi/mtlo and flags divide by zero.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH       = DIV_WIDTH,
  parameter int DIV_LATENCY = DIV_LATENCY_DEF
) (
  input logic            clk,
  input logic            reset,
  div_sequencer_if.slave bus
);

  localparam int               CNT_W    = $clog2(DIV_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_LATENCY - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH-1:0] rem_fix, quo_fix;

  // Operands are only treated as negative for the signed (DIV) form.
  assign dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
  assign dvs_neg = bus.is_signed & bus.divisor[WIDTH-1];

  div_sequencer_sign_fix #(.WIDTH(WIDTH)) u_abs_dvd (
    .neg_i  (dvd_neg),
    .data_i (bus.dividend),
    .data_o (dvd_abs)
  );

  div_sequencer_sign_fix #(.WIDTH(WIDTH)) u_abs_dvs (
    .neg_i  (dvs_neg),
    .data_i (bus.divisor),
    .data_o (dvs_abs)
  );

  // Remainder takes the dividend's sign, quotient the XOR of both signs.
  div_sequencer_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .neg_i  (r_neg_q),
    .data_i (bus.div_rem_in),
    .data_o (rem_fix)
  );

  div_sequencer_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
    .neg_i  (q_neg_q),
    .data_i (bus.div_quo_in),
    .data_o (quo_fix)
  );

  // Next-state logic: FSM, iteration counter, operand latch and HI/LO updates.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
        if (bus.start) begin
          if (bus.divisor == '0) begin
            state_d = ST_ZERO;
          end else begin
            dvd_d   = dvd_abs;
            dvs_d   = dvs_abs;
            q_neg_d = dvd_neg ^ dvs_neg;
            r_neg_d = dvd_neg;
            count_d = '0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bus.div_zero_in) begin
          state_d = ST_ZERO;
        end else begin
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_CNT) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        hi_d    = rem_fix;
        lo_d    = quo_fix;
        state_d = ST_IDLE;
      end
      ST_ZERO: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Status and core controls decode straight from the registered state.
  assign bus.div_en       = (state_q == ST_RUN);
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.done         = (state_q == ST_COMMIT);
  assign bus.div_zero     = (state_q == ST_ZERO);
  assign bus.div_dividend = dvd_q;
  assign bus.div_divisor  = dvs_q;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer with a behavioural divider-core model.
module tb_div_sequencer;

  localparam int LAT = 33;

  logic clk;
  logic reset;
  logic force_zero;
  int   checks = 0;
  int   errors = 0;
  int   core_cnt = 0;
  int   en_cycles = 0;

  div_sequencer_if #(.WIDTH(32)) bus ();

  div_sequencer #(.WIDTH(32), .DIV_LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: results are only meaningful after LAT consecutive enabled cycles.
  always @(posedge clk) begin
    core_cnt  <= (bus.div_en === 1'b1) ? core_cnt + 1 : 0;
    en_cycles <= en_cycles + ((bus.div_en === 1'b1) ? 1 : 0);
  end

  always_comb begin
    bus.div_quo_in = 32'hDEAD_BEEF;
    bus.div_rem_in = 32'hBAAD_F00D;
    if (core_cnt >= LAT && bus.div_divisor != 32'd0) begin
      bus.div_quo_in = bus.div_dividend / bus.div_divisor;
      bus.div_rem_in = bus.div_dividend % bus.div_divisor;
    end
  end

  assign bus.div_zero_in = force_zero;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: MIPS DIV/DIVU semantics via wide integer arithmetic, truncated to 32 bits.
  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    el = 32'(sa / sb);
    eh = 32'(sa % sb);
  endfunction

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    bus.hi_we = 1'b1; bus.wdata = h;
    tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = l;
    tick();
    bus.lo_we = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic wr, input logic [31:0] w);
    logic [31:0] eh, el;
    int k, base;
    logic saw_zero;
    ref_div(s, a, b, eh, el);
    base = en_cycles;
    bus.start = 1'b1; bus.is_signed = s; bus.dividend = a; bus.divisor = b;
    bus.hi_we = wr; bus.wdata = w;
    tick();
    bus.start = 1'b0; bus.hi_we = 1'b0;
    bus.is_signed = ~s; bus.dividend = $urandom; bus.divisor = $urandom;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL %s busy after start: got %b, expected 1", tag, bus.busy);
    end
    if (wr) begin
      checks++;
      if (bus.hi !== w) begin
        errors++; $display("FAIL %s mthi with start: got %h, expected %h", tag, bus.hi, w);
      end
    end
    k = 0; saw_zero = 1'b0;
    while (bus.done !== 1'b1 && k < 100) begin
      saw_zero = saw_zero | (bus.div_zero === 1'b1);
      tick(); k++;
    end
    checks++;
    if (k != LAT) begin
      errors++; $display("FAIL %s latency: got %0d cycles, expected %0d", tag, k, LAT);
    end
    checks++;
    if (saw_zero) begin
      errors++; $display("FAIL %s spurious div_zero: got 1, expected 0", tag);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL %s idle after done: done=%b busy=%b, expected 0/0", tag, bus.done, bus.busy);
    end
    checks++;
    if (bus.hi !== eh) begin
      errors++; $display("FAIL %s hi: got %h, expected %h", tag, bus.hi, eh);
    end
    checks++;
    if (bus.lo !== el) begin
      errors++; $display("FAIL %s lo: got %h, expected %h", tag, bus.lo, el);
    end
    checks++;
    if (en_cycles - base != LAT) begin
      errors++; $display("FAIL %s div_en cycles: got %0d, expected %0d", tag, en_cycles - base, LAT);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++; $display("FAIL reset hilo: got %h/%h, expected 0/0", bus.hi, bus.lo);
    end
    checks++;
    if ({bus.busy, bus.done, bus.div_zero, bus.div_en} !== 4'b0000) begin
      errors++; $display("FAIL reset status: got %b, expected 0000",
                         {bus.busy, bus.done, bus.div_zero, bus.div_en});
    end
    #3 reset = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    run_op("divu_100_7",   1'b0, 32'd100,        32'd7,          1'b0, 32'd0);
    run_op("div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          1'b0, 32'd0);
    run_op("div_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  1'b0, 32'd0);
    run_op("div_min_m1",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0);
    run_op("divu_big",     1'b0, 32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 32'd0);
    run_op("start_mthi",   1'b1, 32'hFFFF_FC18,  32'd9,          1'b1, 32'hCAFE_0001);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_first",  1'b0, 32'd12345, 32'd100, 1'b0, 32'd0);
    run_op("b2b_second", 1'b1, 32'hFFFF_0000, 32'd3, 1'b0, 32'd0);
  endtask

  task automatic test_div_zero();
    int base;
    write_hilo(32'h0000_AAAA, 32'h0000_5555);
    checks++;
    if (bus.hi !== 32'h0000_AAAA || bus.lo !== 32'h0000_5555) begin
      errors++; $display("FAIL mthi_mtlo: got %h/%h, expected 0000aaaa/00005555", bus.hi, bus.lo);
    end
    base = en_cycles;
    bus.start = 1'b1; bus.is_signed = 1'($urandom); bus.dividend = $urandom; bus.divisor = 32'd0;
    tick();
    bus.start = 1'b0;
    checks++;
    if ({bus.div_zero, bus.div_en, bus.busy, bus.done} !== 4'b1010) begin
      errors++; $display("FAIL divzero pulse: zero/en/busy/done got %b, expected 1010",
                         {bus.div_zero, bus.div_en, bus.busy, bus.done});
    end
    tick();
    checks++;
    if (bus.div_zero !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL divzero end: zero=%b busy=%b, expected 0/0", bus.div_zero, bus.busy);
    end
    checks++;
    if (bus.hi !== 32'h0000_AAAA || bus.lo !== 32'h0000_5555 || en_cycles != base) begin
      errors++; $display("FAIL divzero hold: hi=%h lo=%h en=%0d, expected 0000aaaa/00005555/0",
                         bus.hi, bus.lo, en_cycles - base);
    end
  endtask

  task automatic test_busy();
    logic [31:0] eh, el;
    int k;
    write_hilo(32'h0000_1357, 32'h0000_2468);
    ref_div(1'b1, 32'hFFFF_FC18, 32'd7, eh, el);
    bus.start = 1'b1; bus.is_signed = 1'b1; bus.dividend = 32'hFFFF_FC18; bus.divisor = 32'd7;
    tick();
    bus.start = 1'b0;
    k = 0;
    repeat (5) begin tick(); k++; end
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd3;
    bus.hi_we = 1'b1; bus.wdata = 32'hFFFF_FFFF;
    tick(); k++;
    bus.start = 1'b0; bus.hi_we = 1'b0;
    checks++;
    if (bus.hi !== 32'h0000_1357) begin
      errors++; $display("FAIL busy mthi ignored: got %h, expected 00001357", bus.hi);
    end
    while (bus.done !== 1'b1 && k < 100) begin tick(); k++; end
    checks++;
    if (k != LAT) begin
      errors++; $display("FAIL busy latency: got %0d cycles, expected %0d", k, LAT);
    end
    tick();
    checks++;
    if (bus.hi !== eh || bus.lo !== el) begin
      errors++; $display("FAIL busy result: got %h/%h, expected %h/%h", bus.hi, bus.lo, eh, el);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL busy restart: got busy=%b, expected 0", bus.busy);
    end
  endtask

  task automatic test_zero_in();
    write_hilo(32'h0000_2468, 32'h0000_1357);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    force_zero = 1'b1;
    tick();
    force_zero = 1'b0;
    checks++;
    if ({bus.div_zero, bus.div_en, bus.done} !== 3'b100) begin
      errors++; $display("FAIL core zero: zero/en/done got %b, expected 100",
                         {bus.div_zero, bus.div_en, bus.done});
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'h0000_2468 || bus.lo !== 32'h0000_1357) begin
      errors++; $display("FAIL core zero hold: busy=%b hi=%h lo=%h, expected 0/00002468/00001357",
                         bus.busy, bus.hi, bus.lo);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic s;
    for (int i = 0; i < 20; i++) begin
      s = 1'($urandom);
      a = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(1, 9));
        1: b = -32'($urandom_range(1, 9));
        2: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if (b == 32'd0) b = 32'd1;
      run_op($sformatf("rand%0d", i), s, a, b, 1'b0, 32'd0);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd999; bus.divisor = 32'd4;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++; $display("FAIL midreset hilo: got %h/%h, expected 0/0", bus.hi, bus.lo);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.div_en !== 1'b0) begin
      errors++; $display("FAIL midreset status: busy=%b en=%b, expected 0/0", bus.busy, bus.div_en);
    end
    #2 reset = 1'b1;
    bad = 0;
    repeat (40) begin
      tick();
      if (bus.done === 1'b1 || bus.div_zero === 1'b1 || bus.div_en === 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL midreset quiet: got %0d active cycles, expected 0", bad);
    end
  endtask

  initial begin
    force_zero    = 1'b0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd0;
    bus.divisor   = 32'd0;
    bus.hi_we     = 1'b0;
    bus.lo_we     = 1'b0;
    bus.wdata     = 32'd0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_div_zero();
    test_busy();
    test_zero_in();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
